// File: rtl/reg_clear_sequencer_pkg.sv
// Shared types and helpers for the register-clear sequencer: FSM state encoding,
// quarter geometry and the per-quarter occupancy reduction.
package reg_clear_sequencer_pkg;

    localparam int REG_CLR_QUARTERS = 4;
    localparam int REG_CLR_QWIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } reg_clr_state_e;

    // One bit per quarter: set when any register in that quarter is to be cleared.
    function automatic logic [REG_CLR_QUARTERS-1:0] quarter_nonzero(input logic [31:0] m);
        logic [REG_CLR_QUARTERS-1:0] r;
        for (int q = 0; q < REG_CLR_QUARTERS; q++) begin
            r[q] = |m[q*REG_CLR_QWIDTH +: REG_CLR_QWIDTH];
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_clear_sequencer_quarter_picker.sv
// Combinational picker: selects the NR_PORTS lowest set quarters of the pending
// vector (ascending, one per port) and reports what is left afterwards.
module reg_clear_quarter_picker
    import reg_clear_sequencer_pkg::*;
#(
    parameter int NR_PORTS = 2
) (
    input  logic [REG_CLR_QUARTERS-1:0]      pending,
    output logic [NR_PORTS-1:0]              pick_valid,
    output logic [NR_PORTS-1:0][1:0]         pick_idx,
    output logic [REG_CLR_QUARTERS-1:0]      remaining
);

    // rank[q] = number of set pending bits strictly below quarter q
    logic [REG_CLR_QUARTERS-1:0][2:0] rank;

    always_comb begin
        logic [2:0] acc;
        acc  = 3'd0;
        rank = '0;
        for (int q = 0; q < REG_CLR_QUARTERS; q++) begin
            rank[q] = acc;
            acc     = acc + {2'b00, pending[q]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NR_PORTS; gi++) begin : g_port
            logic       hit;
            logic [1:0] idx;
            always_comb begin
                hit = 1'b0;
                idx = 2'd0;
                for (int q = 0; q < REG_CLR_QUARTERS; q++) begin
                    if (pending[q] && (rank[q] == 3'(gi))) begin
                        hit = 1'b1;
                        idx = 2'(q);
                    end
                end
            end
            assign pick_valid[gi] = hit;
            assign pick_idx[gi]   = idx;
        end

        for (gi = 0; gi < REG_CLR_QUARTERS; gi++) begin : g_rem
            assign remaining[gi] = pending[gi] & (rank[gi] >= 3'(NR_PORTS));
        end
    endgenerate

endmodule

// File: rtl/reg_clear_sequencer.sv
// Sequences a 32-bit register-clear mask into per-port quarter beats and reports completion.
// Optional build macro REG_CLEAR_PERF_EN adds the cleared-register counter output.
module reg_clear_sequencer
    import reg_clear_sequencer_pkg::*;
#(
    parameter int NR_PORTS      = 2,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [31:0]                   req_mask_i,
    input  logic                          req_fpr_i,
    input  logic [TRANS_ID_BITS-1:0]      req_trans_id_i,
    output logic [NR_PORTS-1:0]           clr_o,
    output logic [NR_PORTS-1:0][7:0]      mask_o,
    output logic [NR_PORTS-1:0][1:0]      quarter_o,
    output logic                          fpr_o,
    output logic                          busy_o,
    output logic                          done_valid_o,
    output logic [TRANS_ID_BITS-1:0]      done_trans_id_o
`ifdef REG_CLEAR_PERF_EN
    ,
    output logic [31:0]                   cleared_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_CLEAR = CLEAR;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]                   state_reg;
    logic [REG_CLR_QUARTERS-1:0]  pending_reg;
    logic [31:0]                  mask_reg;
    logic                         fpr_reg;
    logic [TRANS_ID_BITS-1:0]     id_reg;

    logic [31:0]                  req_mask_eff;
    logic [REG_CLR_QUARTERS-1:0]  req_pending;
    logic [NR_PORTS-1:0]          pick_valid;
    logic [NR_PORTS-1:0][1:0]     pick_idx;
    logic [REG_CLR_QUARTERS-1:0]  remaining;
    logic                         beat_en;

    // x0 is hard-wired zero in the GPR file, so it never needs a clear beat.
    assign req_mask_eff = {req_mask_i[31:1], req_mask_i[0] & req_fpr_i};
    assign req_pending  = quarter_nonzero(req_mask_eff);

    reg_clear_quarter_picker #(
        .NR_PORTS (NR_PORTS)
    ) u_picker (
        .pending    (pending_reg),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx),
        .remaining  (remaining)
    );

    assign beat_en = (state_reg == ST_CLEAR) & ~flush_i;

    genvar gi;
    generate
        for (gi = 0; gi < NR_PORTS; gi++) begin : g_beat
            logic clr;
            assign clr            = beat_en & pick_valid[gi];
            assign clr_o[gi]      = clr;
            assign mask_o[gi]     = clr ? mask_reg[{pick_idx[gi], 3'b000} +: REG_CLR_QWIDTH] : 8'h00;
            assign quarter_o[gi]  = clr ? pick_idx[gi] : 2'd0;
        end
    endgenerate

    assign req_ready_o     = (state_reg == ST_IDLE) & ~flush_i;
    assign busy_o          = (state_reg != ST_IDLE);
    assign fpr_o           = (state_reg != ST_IDLE) & fpr_reg;
    assign done_valid_o    = (state_reg == ST_DONE) & ~flush_i;
    assign done_trans_id_o = done_valid_o ? id_reg : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            pending_reg <= '0;
            mask_reg    <= '0;
            fpr_reg     <= 1'b0;
            id_reg      <= '0;
        end else if (flush_i) begin
            state_reg   <= ST_IDLE;
            pending_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        mask_reg    <= req_mask_eff;
                        fpr_reg     <= req_fpr_i;
                        id_reg      <= req_trans_id_i;
                        pending_reg <= req_pending;
                        state_reg   <= (req_pending != '0) ? ST_CLEAR : ST_DONE;
                    end
                end
                ST_CLEAR: begin
                    pending_reg <= remaining;
                    if (remaining == '0) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef REG_CLEAR_PERF_EN
    logic [31:0] cnt_reg;
    logic [5:0]  beat_bits;
    logic [32:0] cnt_sum;

    // mask_o is already zero on idle ports and in flushed cycles.
    always_comb begin
        beat_bits = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            for (int b = 0; b < REG_CLR_QWIDTH; b++) begin
                beat_bits = beat_bits + {5'b0, mask_o[k][b]};
            end
        end
    end

    assign cnt_sum = {1'b0, cnt_reg} + {27'b0, beat_bits};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_sum[32] ? '1 : cnt_sum[31:0];
        end
    end

    assign cleared_cnt_o = cnt_reg;
`endif

endmodule

// File: tb/tb_reg_clear_sequencer.sv
// Scoreboard bench for reg_clear_sequencer: per-cycle expected beats are queued when a
// request is driven and compared cycle by cycle as the sequencer produces them.
module tb_reg_clear_sequencer;

    localparam int NP = 2;
    localparam int TW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_mask;
    logic                 req_fpr;
    logic [TW-1:0]        req_id;
    logic [NP-1:0]        clr;
    logic [NP-1:0][7:0]   mask;
    logic [NP-1:0][1:0]   quarter;
    logic                 fpr;
    logic                 busy;
    logic                 done_valid;
    logic [TW-1:0]        done_id;
`ifdef REG_CLEAR_PERF_EN
    logic [31:0]          cleared_cnt;
`endif

    always #5 clk = ~clk;

    reg_clear_sequencer #(
        .NR_PORTS      (NP),
        .TRANS_ID_BITS (TW)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_mask_i      (req_mask),
        .req_fpr_i       (req_fpr),
        .req_trans_id_i  (req_id),
        .clr_o           (clr),
        .mask_o          (mask),
        .quarter_o       (quarter),
        .fpr_o           (fpr),
        .busy_o          (busy),
        .done_valid_o    (done_valid),
        .done_trans_id_o (done_id)
`ifdef REG_CLEAR_PERF_EN
        ,
        .cleared_cnt_o   (cleared_cnt)
`endif
    );

    typedef struct packed {
        logic              chk;
        logic [NP-1:0]     clr;
        logic [NP*8-1:0]   mask;
        logic [NP*2-1:0]   quarter;
        logic              fpr;
        logic              busy;
        logic              ready;
        logic              done;
        logic [TW-1:0]     id;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned perf_exp = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e       = '0;
        e.chk   = 1'b1;
        e.ready = 1'b1;
        return e;
    endfunction

    // Builds the expected cycle-by-cycle trace from T+1; abort_cyc cuts it short with flush or reset.
    task automatic build(input logic [31:0] m, input logic f, input logic [TW-1:0] id,
                         input int abort_cyc, input bit abort_rst);
        logic [31:0] em;
        int          ql[$];
        int          nb;
        int          cyc;
        int          bits;
        exp_t        e;
        em  = f ? m : {m[31:1], 1'b0};
        for (int q = 0; q < 4; q++) if (em[q*8 +: 8] != 8'h00) ql.push_back(q);
        nb  = (ql.size() + NP - 1) / NP;
        cyc = 0;
        for (int b = 0; b < nb; b++) begin
            e      = '0;
            e.chk  = 1'b1;
            e.fpr  = f;
            e.busy = 1'b1;
            bits   = 0;
            for (int k = 0; k < NP; k++) begin
                if (b*NP + k < ql.size()) begin
                    int q;
                    q = ql[b*NP + k];
                    e.clr[k]            = 1'b1;
                    e.mask[k*8 +: 8]    = em[q*8 +: 8];
                    e.quarter[k*2 +: 2] = 2'(q);
                    for (int i = 0; i < 8; i++) bits += int'(em[q*8 + i]);
                end
            end
            if (cyc == abort_cyc) begin
                if (abort_rst) begin
                    e.chk    = 1'b0;
                    perf_exp = 0;
                end else begin
                    e.clr = '0; e.mask = '0; e.quarter = '0;
                end
                exp_q.push_back(e);
                exp_q.push_back(idle_rec());
                return;
            end
            perf_exp += bits;
            exp_q.push_back(e);
            cyc++;
        end
        e      = '0;
        e.chk  = 1'b1;
        e.fpr  = f;
        e.busy = 1'b1;
        e.done = 1'b1;
        e.id   = id;
        if (cyc == abort_cyc) begin
            e.done = 1'b0;
            if (abort_rst) begin
                e.chk    = 1'b0;
                perf_exp = 0;
            end
        end
        exp_q.push_back(e);
        exp_q.push_back(idle_rec());
    endtask

    // Entered and left mid-cycle with the sequencer idle.
    task automatic send(input logic [31:0] m, input logic f, input logic [TW-1:0] id,
                        input int abort_cyc, input bit abort_rst, input bit junk);
        exp_t e;
        int   i;
        $display("txn mask=%08h fpr=%0d id=%0d abort_cyc=%0d rst=%0d perf_model=%0d",
                 m, f, id, abort_cyc, abort_rst, perf_exp);
        check_eq("ready_before_req", 64'(req_ready), 64'd1);
        check_eq("busy_before_req", 64'(busy), 64'd0);
        build(m, f, id, abort_cyc, abort_rst);
        req_valid = 1'b1;
        req_mask  = m;
        req_fpr   = f;
        req_id    = id;
        @(negedge clk);
        req_valid = junk;
        req_mask  = ~m;
        req_fpr   = ~f;
        req_id    = ~id;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (i == abort_cyc) begin
                if (abort_rst) rst_n = 1'b0;
                else           flush = 1'b1;
            end
            if (e.ready) req_valid = 1'b0;
            #1;
            if (e.chk) begin
                check_eq("clr",     64'(clr),        64'(e.clr));
                check_eq("mask",    64'(mask),       64'(e.mask));
                check_eq("quarter", 64'(quarter),    64'(e.quarter));
                check_eq("fpr",     64'(fpr),        64'(e.fpr));
                check_eq("busy",    64'(busy),       64'(e.busy));
                check_eq("ready",   64'(req_ready),  64'(e.ready));
                check_eq("done",    64'(done_valid), 64'(e.done));
                if (e.done) check_eq("done_id", 64'(done_id), 64'(e.id));
            end
            if (exp_q.size() > 0) begin
                @(negedge clk);
                flush = 1'b0;
                rst_n = 1'b1;
            end
            i++;
        end
`ifdef REG_CLEAR_PERF_EN
        check_eq("perf_cnt", 64'(cleared_cnt), 64'(perf_exp));
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_mask  = '0;
        req_fpr   = 1'b0;
        req_id    = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_busy",  64'(busy),      64'd0);
        check_eq("rst_clr",   64'(clr),       64'd0);
        check_eq("rst_done",  64'(done_valid), 64'd0);
        check_eq("rst_fpr",   64'(fpr),       64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h8000_0101, 1'b0, 3'd5, -1, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 3'd3, -1, 1'b0, 1'b1);
        send(32'h0000_0000, 1'b0, 3'd2, -1, 1'b0, 1'b0);
        send(32'h0000_0001, 1'b0, 3'd4, -1, 1'b0, 1'b0);
        send(32'h0000_0001, 1'b1, 3'd6, -1, 1'b0, 1'b0);
        send(32'h0F0F_0F00, 1'b0, 3'd1, 1, 1'b0, 1'b0);
        send(32'h0000_00FE, 1'b0, 3'd7, -1, 1'b0, 1'b0);

        // Flush while idle must block acceptance.
        flush     = 1'b1;
        req_valid = 1'b1;
        req_mask  = 32'hFFFF_FFFF;
        #1;
        check_eq("flush_idle_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("flush_idle_busy", 64'(busy), 64'd0);

        send(32'hFFFF_FFFF, 1'b0, 3'd0, 0, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 1'b1, 3'd6, 1, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic [31:0]   rm;
            logic          rf;
            logic [TW-1:0] rid;
            rm  = $urandom;
            if (r[0]) rm = rm & 32'h00FF_00FF;
            rf  = 1'($urandom_range(0, 1));
            rid = TW'($urandom_range(0, 7));
            send(rm, rf, rid, -1, 1'b0, r[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
